// File: rtl/ad5541_spi_rx.sv
// -----------------------------------------------------------------------------
// ad5541_spi_rx
//
// SPI slave receiver modelling the AD5541 DAC end of a 16-bit DAC link.
// The asynchronous pins are oversampled on clk. Words are captured MSB first
// on sclk rising edges. Frame length is checked when csn rises. An LDAC
// falling edge copies the last good word into the DAC output register.
//
// Ports:
//   clk        in   system clock, all logic on its rising edge
//   reset      in   synchronous active-high reset
//   csn        in   SPI chip select, active low, asynchronous
//   sclk       in   SPI clock, asynchronous, idles low
//   mosi       in   SPI data, sampled on sclk rising edge
//   ldac       in   load-DAC strobe, active low, asynchronous
//   rx_data    out  last valid received word
//   dv         out  one-cycle pulse, rx_data updated
//   frame_err  out  one-cycle pulse, frame ended with a wrong bit count
//   dac_code   out  DAC output register
//   dac_update out  one-cycle pulse, dac_code updated
// -----------------------------------------------------------------------------
module ad5541_spi_rx #(
  parameter int DATA_WIDTH  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  csn,
  input  logic                  sclk,
  input  logic                  mosi,
  input  logic                  ldac,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  dv,
  output logic                  frame_err,
  output logic [DATA_WIDTH-1:0] dac_code,
  output logic                  dac_update
);

  localparam int CNT_W    = $clog2(DATA_WIDTH + 2);
  localparam int SETTLE_W = $clog2(SYNC_STAGES + 2);

  localparam logic [CNT_W-1:0]    CNT_FULL = CNT_W'(DATA_WIDTH);
  localparam logic [CNT_W-1:0]    CNT_SAT  = CNT_W'(DATA_WIDTH + 1);
  localparam logic [SETTLE_W-1:0] SETTLE_N = SETTLE_W'(SYNC_STAGES + 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // ---------------------------------------------------------------------------
  // Input synchronizers. The reset values match the idle levels of the pins,
  // so no edge appears when reset is released with the link idle.
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] r_csn_sync;
  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic [SYNC_STAGES-1:0] r_ldac_sync;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_csn_sync  <= '1;
      r_sclk_sync <= '0;
      r_mosi_sync <= '0;
      r_ldac_sync <= '1;
    end else begin
      r_csn_sync  <= {r_csn_sync[SYNC_STAGES-2:0], csn};
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
      r_ldac_sync <= {r_ldac_sync[SYNC_STAGES-2:0], ldac};
    end
  end

  logic w_csn_s;
  logic w_sclk_s;
  logic w_mosi_s;
  logic w_ldac_s;

  assign w_csn_s  = r_csn_sync[SYNC_STAGES-1];
  assign w_sclk_s = r_sclk_sync[SYNC_STAGES-1];
  assign w_mosi_s = r_mosi_sync[SYNC_STAGES-1];
  assign w_ldac_s = r_ldac_sync[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // Edge detection, one flop behind the synchronizer output.
  // ---------------------------------------------------------------------------
  logic r_csn_d;
  logic r_sclk_d;
  logic r_ldac_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_csn_d  <= 1'b1;
      r_sclk_d <= 1'b0;
      r_ldac_d <= 1'b1;
    end else begin
      r_csn_d  <= w_csn_s;
      r_sclk_d <= w_sclk_s;
      r_ldac_d <= w_ldac_s;
    end
  end

  logic w_csn_fall;
  logic w_csn_rise;
  logic w_sclk_rise;
  logic w_ldac_fall;

  assign w_csn_fall  = ~w_csn_s & r_csn_d;
  assign w_csn_rise  = w_csn_s & ~r_csn_d;
  assign w_sclk_rise = w_sclk_s & ~r_sclk_d;
  assign w_ldac_fall = ~w_ldac_s & r_ldac_d;

  // ---------------------------------------------------------------------------
  // Post-reset arming. The synchronizers preset csn high, so if the pin is
  // still low when reset drops, the pipeline would flush 1->0 and fake a
  // falling edge. Frame starts are therefore only accepted once the pipeline
  // has been refilled from the pin and csn has been seen high.
  // ---------------------------------------------------------------------------
  logic [SETTLE_W-1:0] r_settle;
  logic                r_armed;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_settle <= '0;
      r_armed  <= 1'b0;
    end else begin
      if (r_settle != SETTLE_N) begin
        r_settle <= r_settle + 1'b1;
      end
      if ((r_settle == SETTLE_N) && w_csn_s && r_csn_d) begin
        r_armed <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Frame FSM, receive / DAC registers and pulses.
  // ---------------------------------------------------------------------------
  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [CNT_W-1:0]      r_cnt;
  logic [DATA_WIDTH-1:0] r_rx_data;
  logic [DATA_WIDTH-1:0] r_dac_code;
  logic                  r_dv;
  logic                  r_frame_err;
  logic                  r_dac_update;
  logic                  r_pending;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_shift      <= '0;
      r_cnt        <= '0;
      r_rx_data    <= '0;
      r_dac_code   <= '0;
      r_dv         <= 1'b0;
      r_frame_err  <= 1'b0;
      r_dac_update <= 1'b0;
      r_pending    <= 1'b0;
    end else begin
      r_dv         <= 1'b0;
      r_frame_err  <= 1'b0;
      r_dac_update <= 1'b0;

      // LDAC load of the held word. A valid frame end in the same cycle
      // overrides this below so that the newest word wins.
      if (w_ldac_fall && r_pending) begin
        r_dac_code   <= r_rx_data;
        r_dac_update <= 1'b1;
        r_pending    <= 1'b0;
      end

      case (r_state)
        IDLE: begin
          if (w_csn_fall && r_armed) begin
            r_shift <= '0;
            r_cnt   <= '0;
            r_state <= SHIFT;
          end
        end

        SHIFT: begin
          // csn rise takes priority: a coincident sclk edge is discarded and
          // the length check sees the pre-edge count.
          if (w_csn_rise) begin
            r_state <= IDLE;
            if (r_cnt == CNT_FULL) begin
              r_rx_data <= r_shift;
              r_dv      <= 1'b1;
              // ldac low (held, or falling right now) means transparent load
              if (!w_ldac_s) begin
                r_dac_code   <= r_shift;
                r_dac_update <= 1'b1;
                r_pending    <= 1'b0;
              end else begin
                r_pending <= 1'b1;
              end
            end else begin
              r_frame_err <= 1'b1;
            end
          end else if (w_sclk_rise) begin
            r_shift <= {r_shift[DATA_WIDTH-2:0], w_mosi_s};
            if (r_cnt != CNT_SAT) begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign rx_data    = r_rx_data;
  assign dv         = r_dv;
  assign frame_err  = r_frame_err;
  assign dac_code   = r_dac_code;
  assign dac_update = r_dac_update;

endmodule

// File: tb/tb_ad5541_spi_rx.sv
// -----------------------------------------------------------------------------
// tb_ad5541_spi_rx
//
// Drives asynchronous SPI/LDAC pin activity into ad5541_spi_rx and compares
// pulse counts and register contents against a word-level model after every
// transaction (frame, LDAC pulse, LDAC level change, reset).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ad5541_spi_rx;

  localparam int DW   = 16;
  localparam int HALF = 6;   // sclk half period in clk cycles

  logic          clk   = 1'b0;
  logic          reset = 1'b1;
  logic          csn   = 1'b1;
  logic          sclk  = 1'b0;
  logic          mosi  = 1'b0;
  logic          ldac  = 1'b1;
  logic [DW-1:0] rx_data;
  logic          dv;
  logic          frame_err;
  logic [DW-1:0] dac_code;
  logic          dac_update;

  ad5541_spi_rx #(
    .DATA_WIDTH  (DW),
    .SYNC_STAGES (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .csn        (csn),
    .sclk       (sclk),
    .mosi       (mosi),
    .ldac       (ldac),
    .rx_data    (rx_data),
    .dv         (dv),
    .frame_err  (frame_err),
    .dac_code   (dac_code),
    .dac_update (dac_update)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Output monitor: counts pulse cycles, sampled on the falling edge.
  // ---------------------------------------------------------------------------
  int dv_cnt      = 0;
  int err_cnt     = 0;
  int upd_cnt     = 0;
  int upd_dv_cnt  = 0;
  int overlap_cnt = 0;

  always @(negedge clk) begin
    if (!reset) begin
      if (dv)               dv_cnt++;
      if (frame_err)        err_cnt++;
      if (dac_update)       upd_cnt++;
      if (dac_update && dv) upd_dv_cnt++;
      if (dv && frame_err)  overlap_cnt++;
    end
  end

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: the DAC as seen from the link, at word level.
  // ---------------------------------------------------------------------------
  logic [DW-1:0] m_rx      = '0;
  logic [DW-1:0] m_dac     = '0;
  bit            m_pend    = 1'b0;
  bit            m_ldac_lo = 1'b0;

  int e_dv, e_err, e_upd, e_coinc;

  task automatic model_frame(input logic [31:0] w, input int n);
    e_dv = 0; e_err = 0; e_upd = 0; e_coinc = 0;
    if (n == DW) begin
      e_dv = 1;
      m_rx = w[DW-1:0];
      if (m_ldac_lo) begin
        m_dac   = m_rx;
        m_pend  = 1'b0;
        e_upd   = 1;
        e_coinc = 1;
      end else begin
        m_pend = 1'b1;
      end
    end else begin
      e_err = 1;
    end
  endtask

  task automatic model_ldac_fall();
    e_dv = 0; e_err = 0; e_upd = 0; e_coinc = 0;
    m_ldac_lo = 1'b1;
    if (m_pend) begin
      m_dac  = m_rx;
      m_pend = 1'b0;
      e_upd  = 1;
    end
  endtask

  task automatic model_reset();
    e_dv = 0; e_err = 0; e_upd = 0; e_coinc = 0;
    m_rx   = '0;
    m_dac  = '0;
    m_pend = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Transaction bookkeeping
  // ---------------------------------------------------------------------------
  int b_dv, b_err, b_upd, b_coinc;

  task automatic begin_txn();
    b_dv    = dv_cnt;
    b_err   = err_cnt;
    b_upd   = upd_cnt;
    b_coinc = upd_dv_cnt;
  endtask

  task automatic end_txn(input string tag);
    @(negedge clk);
    check($sformatf("%s dv", tag),        dv_cnt - b_dv,         e_dv);
    check($sformatf("%s frame_err", tag), err_cnt - b_err,       e_err);
    check($sformatf("%s dac_update", tag), upd_cnt - b_upd,      e_upd);
    check($sformatf("%s upd_with_dv", tag), upd_dv_cnt - b_coinc, e_coinc);
    check($sformatf("%s rx_data", tag),   rx_data,               m_rx);
    check($sformatf("%s dac_code", tag),  dac_code,              m_dac);
    $display("txn %-14s dv=%0d err=%0d upd=%0d rx_data=0x%04h dac_code=0x%04h",
             tag, dv_cnt - b_dv, err_cnt - b_err, upd_cnt - b_upd, rx_data, dac_code);
  endtask

  // ---------------------------------------------------------------------------
  // Pin drivers; a sub-cycle offset keeps edges asynchronous to clk.
  // ---------------------------------------------------------------------------
  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #($urandom_range(1, 8));
  endtask

  task automatic send_bits(input logic [31:0] w, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      mosi = w[i];
      wait_cyc(HALF);
      sclk = 1'b1;
      wait_cyc(HALF);
      sclk = 1'b0;
    end
  endtask

  task automatic do_frame(input string tag, input logic [31:0] w, input int n);
    begin_txn();
    csn = 1'b0;
    wait_cyc(HALF);
    send_bits(w, n);
    wait_cyc(HALF);
    csn = 1'b1;
    wait_cyc(10);
    model_frame(w, n);
    end_txn(tag);
  endtask

  task automatic do_ldac_pulse(input string tag);
    begin_txn();
    ldac = 1'b0;
    wait_cyc(8);
    model_ldac_fall();
    ldac = 1'b1;
    m_ldac_lo = 1'b0;
    wait_cyc(10);
    end_txn(tag);
  endtask

  task automatic set_ldac_low(input string tag);
    begin_txn();
    ldac = 1'b0;
    wait_cyc(10);
    model_ldac_fall();
    end_txn(tag);
  endtask

  task automatic set_ldac_high(input string tag);
    begin_txn();
    ldac = 1'b1;
    m_ldac_lo = 1'b0;
    e_dv = 0; e_err = 0; e_upd = 0; e_coinc = 0;
    wait_cyc(10);
    end_txn(tag);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [31:0] w;
    int          n;
    int          sel;

    reset = 1'b1;
    repeat (5) @(posedge clk);
    #1 reset = 1'b0;
    wait_cyc(10);
    @(negedge clk);
    check("reset rx_data",    rx_data,    '0);
    check("reset dac_code",   dac_code,   '0);
    check("reset dv",         dv,         1'b0);
    check("reset frame_err",  frame_err,  1'b0);
    check("reset dac_update", dac_update, 1'b0);

    // Word, then LDAC four sclk periods later
    do_frame("a5c3", 32'hA5C3, 16);
    wait_cyc(4 * 2 * HALF);
    do_ldac_pulse("a5c3_ldac");

    // Wrong lengths
    do_frame("len15", $urandom, 15);
    do_frame("len17", $urandom, 17);

    // Transparent mode
    set_ldac_low("ldac_tie");
    do_frame("tr_0001", 32'h0001, 16);
    do_frame("tr_ffff", 32'hFFFF, 16);
    set_ldac_high("ldac_rel");

    // Back-to-back without LDAC, then two pulses
    do_frame("b2b_1234", 32'h1234, 16);
    do_frame("b2b_5678", 32'h5678, 16);
    do_ldac_pulse("b2b_ldac1");
    do_ldac_pulse("b2b_ldac2");

    // Reset in the middle of a frame, csn still low on release
    begin_txn();
    csn = 1'b0;
    wait_cyc(HALF);
    send_bits(32'hBE, 8);
    wait_cyc(2);
    @(posedge clk);
    #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
    send_bits(32'hEF, 8);
    wait_cyc(HALF);
    csn = 1'b1;
    wait_cyc(10);
    end_txn("abort_beef");
    do_frame("after_0f0f", 32'h0F0F, 16);

    // Loopback as the DAC transmitter drives it: word then its ldac strobe
    do_frame("lb_8001", 32'h8001, 16);
    do_ldac_pulse("lb_ldac");

    // Randomized mix
    for (int t = 0; t < 30; t++) begin
      sel = $urandom_range(0, 9);
      if (sel < 4) begin
        do_frame("rnd_frame", $urandom, 16);
      end else if (sel < 6) begin
        n = $urandom_range(12, 20);
        do_frame("rnd_len", $urandom, n);
      end else if (sel < 8) begin
        if (m_ldac_lo) set_ldac_high("rnd_ldac_hi");
        else           do_ldac_pulse("rnd_ldac");
      end else begin
        if (m_ldac_lo) set_ldac_high("rnd_ldac_hi");
        else           set_ldac_low("rnd_ldac_lo");
      end
    end

    check("dv_err_overlap", overlap_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
